// File: rtl/cat_recognizer_pkg.sv
// Shared address map, control-register bit positions and APB FSM states
// for the cat recognizer host interface.
package cat_recognizer_pkg;

  localparam int unsigned FILE_LENGTH    = 4096;
  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_MEM_FIRST = 1;
  localparam int unsigned ADDR_RESULT    = FILE_LENGTH + ADDR_MEM_FIRST;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_BUSY_BIT  = 1;
  localparam int unsigned CTRL_DONE_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } apb_state_e;

endpackage

// File: rtl/image_mem.sv
// Single-port synchronous image RAM: write or read per enabled cycle,
// read data registered one cycle later and held until the next read.
module image_mem #(
  parameter int Width = 24,
  parameter int Depth = 4096,
  parameter int AddrW = 12
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/apb_image_slave.sv
// APB slave for image load, start control and status readback; memory reads
// take one extra wait cycle, everything else completes on the first access cycle.
module apb_image_slave
  import cat_recognizer_pkg::*;
#(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5,
  parameter int file_length      = FILE_LENGTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [Amba_Addr_Depth-1:0]  PADDR,
  input  logic [Amba_Word-1:0]        PWDATA,
  output logic [Amba_Word-1:0]        PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        core_start,
  input  logic                        core_rd_en,
  input  logic [Amba_Addr_Depth-2:0]  core_rd_addr,
  output logic [Amba_Word-1:0]        core_rd_data,
  input  logic                        core_done,
  input  logic [Weight_precision-1:0] core_result
);

  localparam int AD = Amba_Addr_Depth;
  localparam logic [AD-1:0] AddrCtrl     = AD'(ADDR_CTRL);
  localparam logic [AD-1:0] AddrMemFirst = AD'(ADDR_MEM_FIRST);
  localparam logic [AD-1:0] AddrMemLast  = AD'(file_length);
  localparam logic [AD-1:0] AddrResult   = AD'(file_length + ADDR_MEM_FIRST);

  function automatic logic is_mem(input logic [AD-1:0] a);
    return (a >= AddrMemFirst) && (a <= AddrMemLast);
  endfunction

  function automatic logic [AD-2:0] mem_idx(input logic [AD-1:0] a);
    logic [AD-1:0] off;
    off = a - AddrMemFirst;
    return off[AD-2:0];
  endfunction

  apb_state_e state_q, state_d;
  logic [AD-1:0]               addr_q;
  logic [Amba_Word-1:0]        wdata_q, prdata_q, crd_q, mem_rdata, ctrl_word;
  logic                        write_q, rd_launched_q, busy_q, done_q, start_q, crd_vld_q;
  logic [Weight_precision-1:0] result_q;
  logic                        setup, apb_rd_launch, mem_wr, start_acc;
  logic                        acc_mem, acc_ctrl, acc_res, acc_err;
  logic                        mem_en, mem_we;
  logic [AD-2:0]               mem_addr;

  assign setup         = (state_q == IDLE) && PSEL && !PENABLE;
  assign apb_rd_launch = setup && !PWRITE && is_mem(PADDR) && !busy_q;
  assign acc_mem       = is_mem(addr_q);
  assign acc_ctrl      = (addr_q == AddrCtrl);
  assign acc_res       = (addr_q == AddrResult);
  // While the core runs the image is frozen and a second start is refused.
  assign acc_err = !(acc_mem || acc_ctrl || acc_res) || (busy_q && acc_mem) ||
                   (busy_q && acc_ctrl && write_q && wdata_q[CTRL_START_BIT]);

  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_BUSY_BIT] = busy_q;
    ctrl_word[CTRL_DONE_BIT] = done_q;
  end

  always_comb begin
    state_d   = state_q;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = prdata_q;
    mem_wr    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: if (setup) state_d = ACCESS;
      ACCESS: begin
        if (rd_launched_q) begin
          state_d = RDWAIT;
        end else begin
          state_d = IDLE;
          PREADY  = 1'b1;
          if (acc_err) begin
            PSLVERR = 1'b1;
            if (!write_q) PRDATA = '0;
          end else if (!write_q) begin
            PRDATA = acc_ctrl ? ctrl_word : (acc_res ? Amba_Word'(result_q) : '0);
          end else begin
            mem_wr    = acc_mem;
            start_acc = acc_ctrl && wdata_q[CTRL_START_BIT];
          end
        end
      end
      RDWAIT: begin
        state_d = IDLE;
        PREADY  = 1'b1;
        PRDATA  = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Core owns the RAM port while busy; a transfer in reset never writes.
  assign mem_en   = rst && (busy_q ? core_rd_en : (apb_rd_launch || mem_wr));
  assign mem_we   = !busy_q && mem_wr;
  assign mem_addr = busy_q ? core_rd_addr : (mem_wr ? mem_idx(addr_q) : mem_idx(PADDR));

  image_mem #(
    .Width (Amba_Word),
    .Depth (file_length),
    .AddrW (AD - 1)
  ) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      rd_launched_q <= 1'b0;
      prdata_q      <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      crd_vld_q     <= 1'b0;
      crd_q         <= '0;
    end else begin
      if (setup) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
      end
      rd_launched_q <= apb_rd_launch;
      prdata_q      <= PRDATA;
      start_q       <= start_acc;
      if (start_acc) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (core_done && busy_q) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= core_result;
      end
      crd_vld_q <= busy_q && core_rd_en;
      if (crd_vld_q) crd_q <= mem_rdata;
    end
  end

  assign core_start   = start_q;
  assign core_rd_data = crd_vld_q ? mem_rdata : crd_q;

endmodule

// File: tb/tb_apb_image_slave.sv
// Directed bench for apb_image_slave: reset, image load/readback, start/busy,
// core read port, completion status and address error handling.
module tb_apb_image_slave;
  import cat_recognizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, core_start;
  logic        core_rd_en;
  logic [11:0] core_rd_addr;
  logic [23:0] core_rd_data;
  logic        core_done;
  logic [4:0]  core_result;

  int n_vec = 0;
  int n_bad = 0;

  apb_image_slave dut (
    .clk          (clk),
    .rst          (rst),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .core_start   (core_start),
    .core_rd_en   (core_rd_en),
    .core_rd_addr (core_rd_addr),
    .core_rd_data (core_rd_data),
    .core_done    (core_done),
    .core_result  (core_result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [12:0] a, input logic [23:0] d,
                      output logic [23:0] rd, output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    cyc();
    PENABLE = 1'b1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 8) begin
      cyc();
      waits++;
    end
    chk("pready", 32'(PREADY), 32'd1);
    rd  = PRDATA;
    err = PSLVERR;
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [12:0] a, input logic [23:0] d,
                        input logic exp_err);
    logic [23:0] rd;
    logic        err;
    int          waits;
    xfer(1'b1, a, d, rd, err, waits);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_waits"}, 32'(waits), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [12:0] a, input logic [23:0] exp_d,
                        input logic exp_err, input int exp_waits);
    logic [23:0] rd;
    logic        err;
    int          waits;
    xfer(1'b0, a, 24'h0, rd, err, waits);
    chk({tag, "_data"}, 32'(rd), 32'(exp_d));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
  endtask

  initial begin
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    core_rd_en = 1'b0; core_rd_addr = '0; core_done = 1'b0; core_result = '0;
    repeat (3) cyc();
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_pslverr", 32'(PSLVERR), 32'd0);
    chk("reset_start", 32'(core_start), 32'd0);
    chk("reset_prdata", 32'(PRDATA), 32'd0);
    chk("reset_crd", 32'(core_rd_data), 32'd0);
    rst = 1'b1;
    cyc();

    // Reset landing on the access phase of a write must not commit it.
    wr_chk("pre5", 13'd5, 24'h0A0B0C, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 13'd5; PWDATA = 24'hDEAD00;
    cyc();
    PENABLE = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_pready", 32'(PREADY), 32'd0);
      chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
      chk("midrst_start", 32'(core_start), 32'd0);
    end
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    cyc();
    rd_chk("midrst_keep5", 13'd5, 24'h0A0B0C, 1'b0, 1);

    wr_chk("wr1", 13'd1, 24'h123456, 1'b0);
    wr_chk("wr4096", 13'd4096, 24'hABCDEF, 1'b0);
    wr_chk("wr3", 13'd3, 24'h000333, 1'b0);
    wr_chk("wr4095", 13'd4095, 24'h0F0F0F, 1'b0);
    rd_chk("rd1", 13'd1, 24'h123456, 1'b0, 1);
    rd_chk("rd4096", 13'd4096, 24'hABCDEF, 1'b0, 1);
    rd_chk("rd3", 13'd3, 24'h000333, 1'b0, 1);

    rd_chk("ctrl_idle", 13'd0, 24'h000000, 1'b0, 0);
    wr_chk("ctrl_nostart", 13'd0, 24'h000000, 1'b0);
    chk("nostart_pulse", 32'(core_start), 32'd0);
    rd_chk("ctrl_still_idle", 13'd0, 24'h000000, 1'b0, 0);

    wr_chk("start1", 13'd0, 24'h000001, 1'b0);
    chk("start1_pulse", 32'(core_start), 32'd1);
    cyc();
    chk("start1_pulse_end", 32'(core_start), 32'd0);
    rd_chk("ctrl_busy", 13'd0, 24'h000002, 1'b0, 0);

    wr_chk("busy_wr3", 13'd3, 24'h777777, 1'b1);
    rd_chk("busy_rd3", 13'd3, 24'h000000, 1'b1, 0);
    wr_chk("busy_restart", 13'd0, 24'h000001, 1'b1);
    chk("busy_restart_pulse", 32'(core_start), 32'd0);

    core_rd_en = 1'b1; core_rd_addr = 12'd0;
    cyc();
    core_rd_en = 1'b0;
    chk("core_rd0", 32'(core_rd_data), 32'h123456);
    core_rd_en = 1'b1; core_rd_addr = 12'd4095;
    cyc();
    core_rd_en = 1'b0;
    chk("core_rd4095", 32'(core_rd_data), 32'hABCDEF);
    cyc();
    chk("core_rd_hold", 32'(core_rd_data), 32'hABCDEF);

    core_done = 1'b1; core_result = 5'd19;
    cyc();
    core_done = 1'b0; core_result = 5'd0;
    rd_chk("ctrl_done", 13'd0, 24'h000004, 1'b0, 0);
    rd_chk("result19", 13'(ADDR_RESULT), 24'h000013, 1'b0, 0);
    rd_chk("rd3_unchanged", 13'd3, 24'h000333, 1'b0, 1);

    core_rd_en = 1'b1; core_rd_addr = 12'd2;
    cyc();
    cyc();
    core_rd_en = 1'b0;
    chk("core_rd_idle_hold", 32'(core_rd_data), 32'hABCDEF);

    wr_chk("start2", 13'd0, 24'h000001, 1'b0);
    chk("start2_pulse", 32'(core_start), 32'd1);
    rd_chk("ctrl_done_cleared", 13'd0, 24'h000002, 1'b0, 0);
    core_done = 1'b1; core_result = 5'd31;
    cyc();
    core_done = 1'b0; core_result = 5'd0;
    rd_chk("result31", 13'd4097, 24'h00001F, 1'b0, 0);

    core_done = 1'b1; core_result = 5'd7;
    cyc();
    core_done = 1'b0; core_result = 5'd0;
    rd_chk("idle_done_ignored", 13'd4097, 24'h00001F, 1'b0, 0);
    rd_chk("idle_done_ctrl", 13'd0, 24'h000004, 1'b0, 0);

    wr_chk("err_wr4098", 13'd4098, 24'h111111, 1'b1);
    rd_chk("err_rd4098", 13'd4098, 24'h000000, 1'b1, 0);
    wr_chk("err_wr8191", 13'd8191, 24'h222222, 1'b1);
    rd_chk("err_rd8191", 13'd8191, 24'h000000, 1'b1, 0);
    rd_chk("after_err_rd1", 13'd1, 24'h123456, 1'b0, 1);
    rd_chk("after_err_rd4095", 13'd4095, 24'h0F0F0F, 1'b0, 1);
    rd_chk("after_err_rd4096", 13'd4096, 24'hABCDEF, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
